// File: rtl/hpdcache_wrrarb_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_wrrarb_pkg
// Shared constants and helpers for the weighted round-robin arbiter.
//   WRRARB_DEFAULT_WW : default width of weight fields and burst counter
//   eff_weight()      : a programmed weight of zero behaves as one
//   sat_inc()         : increment that sticks at the all-ones value of a field
// -----------------------------------------------------------------------------
package hpdcache_wrrarb_pkg;

  localparam int unsigned WRRARB_DEFAULT_WW = 3;

  // Zero weight would starve the owner of its own first transfer, so it is
  // promoted to one.
  function automatic logic [31:0] eff_weight(input logic [31:0] w);
    return (w == '0) ? 32'd1 : w;
  endfunction

  // Saturating increment of a ww-bit quantity carried in 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned ww);
    logic [31:0] max_v;
    max_v = (32'd1 << ww) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hpdcache_1hot_to_bin.sv
// -----------------------------------------------------------------------------
// hpdcache_1hot_to_bin
// One-hot to binary index converter.
//   val_i [N]  : one-hot (or zero) vector
//   val_o [IW] : index of the set bit, 0 when val_i is zero
// -----------------------------------------------------------------------------
module hpdcache_1hot_to_bin #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  val_i,
  output logic [IW-1:0] val_o
);

  always_comb begin
    val_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (val_i[i]) val_o |= IW'(i);
    end
  end

endmodule

// File: rtl/hpdcache_prio_1hot_encoder.sv
// -----------------------------------------------------------------------------
// hpdcache_prio_1hot_encoder
// Priority encoder with one-hot output: keeps only the lowest set bit.
//   val_i [N] : input vector
//   val_o [N] : lowest set bit of val_i (zero when val_i is zero)
// -----------------------------------------------------------------------------
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);

  // Two's-complement trick: x & -x isolates the least significant set bit.
  assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_wrrarb.sv
// -----------------------------------------------------------------------------
// hpdcache_wrrarb
// Weighted round-robin arbiter. The current owner keeps the grant for up to
// its (runtime) weight of consecutive grants, then the pointer rotates to the
// next requester above it. A grant not yet accepted (ready_i low) is frozen.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   req_i      [N]    : request vector
//   weight_i   [N*WW] : per-requester burst weight, field i at [i*WW +: WW]
//   prio_i     [N]    : high-priority requesters (HPDCACHE_WRRARB_PRIO_EN only)
//   ready_i    : consumer accepts the current grant
//   gnt_o      [N]    : one-hot grant, zero when idle
//   gnt_idx_o  [IW]   : binary index of gnt_o, zero when idle
// Optional feature macro: HPDCACHE_WRRARB_PRIO_EN. When defined, rotation at
// a burst boundary is restricted to requesters that also assert prio_i.
// -----------------------------------------------------------------------------
module hpdcache_wrrarb
  import hpdcache_wrrarb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = WRRARB_DEFAULT_WW,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N*WW-1:0] weight_i,
`ifdef HPDCACHE_WRRARB_PRIO_EN
  input  logic [N-1:0]   prio_i,
`endif
  input  logic           ready_i,
  output logic [N-1:0]   gnt_o,
  output logic [IW-1:0]  gnt_idx_o
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "hpdcache_wrrarb: N must be >= 1");
  end
  if (WW < 1) begin : g_bad_ww
    $fatal(1, "hpdcache_wrrarb: WW must be >= 1");
  end

  // Reset owner is the top requester so the first rotation lands on index 0.
  localparam logic [N-1:0] GNT_RST = N'(1) << (N - 1);

  logic          wait_q;
  logic [N-1:0]  gnt_q;
  logic [WW-1:0] cnt_q;
  logic [WW-1:0] cnt_d;

  logic          any_req;
  logic          keep;
  logic [WW-1:0] w_owner;
  logic [WW-1:0] ew_owner;
  logic [N-1:0]  rot_req;
  logic [N-1:0]  above_mask;
  logic [N-1:0]  gnt_masked;
  logic [N-1:0]  gnt_unmasked;
  logic [N-1:0]  gnt;

  assign any_req = |req_i;

  // Candidate set for rotation and thermometer mask of indices strictly
  // above the owner: (gnt_q | gnt_q-1) covers owner and below.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rot_req = req_i;
`ifdef HPDCACHE_WRRARB_PRIO_EN
    if (|(req_i & prio_i)) rot_req = req_i & prio_i;
`endif
    above_mask = ~(gnt_q | (gnt_q - N'(1)));

    w_owner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) w_owner = weight_i[i*WW +: WW];
    end
  end

  assign ew_owner = WW'(eff_weight(32'(w_owner)));

  // cnt_q == 0 only out of reset: no burst is running yet, so nothing to keep.
  assign keep = (|(req_i & gnt_q)) && (cnt_q != '0) && (cnt_q < ew_owner);

  hpdcache_prio_1hot_encoder #(.N(N)) i_enc_masked (
    .val_i (rot_req & above_mask),
    .val_o (gnt_masked)
  );

  hpdcache_prio_1hot_encoder #(.N(N)) i_enc_unmasked (
    .val_i (rot_req),
    .val_o (gnt_unmasked)
  );

  always_comb begin
    gnt = '0;
    if (keep)             gnt = gnt_q;
    else if (|gnt_masked) gnt = gnt_masked;
    else                  gnt = gnt_unmasked;
  end

  assign cnt_d = keep ? WW'(sat_inc(32'(cnt_q), WW)) : WW'(1);

  assign gnt_o = wait_q ? gnt_q : gnt;

  hpdcache_1hot_to_bin #(.N(N), .IW(IW)) i_gnt_idx (
    .val_i (gnt_o),
    .val_o (gnt_idx_o)
  );

  // Owner and burst count advance only when a new grant is first issued;
  // a held grant (wait_q) leaves them untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= 1'b0;
      gnt_q  <= GNT_RST;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge regardless of statement order.
      wait_q <= ~ready_i & (wait_q | any_req);
      if (!wait_q && any_req) begin
        gnt_q <= gnt;
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_wrrarb.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_wrrarb
// Directed bench for hpdcache_wrrarb (N=4, WW=3). A behavioural model tracks
// owner, burst length and pending hold as plain integers and predicts the
// grant each cycle; directed sequences also pin hand-computed indices.
// Builds with or without HPDCACHE_WRRARB_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_hpdcache_wrrarb;

  localparam int N  = 4;
  localparam int WW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]  prio = '0;
  logic          ready = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;

  int n_pass  = 0;
  int n_total = 0;

  hpdcache_wrrarb #(.N(N), .WW(WW), .IW(IW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .weight_i  (weight),
`ifdef HPDCACHE_WRRARB_PRIO_EN
    .prio_i    (prio),
`endif
    .ready_i   (ready),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_owner;    // index of last owner
  int m_burst;    // grants in current burst, 0 = none since reset
  bit m_waiting;  // a grant is outstanding
  int m_held;     // index held while waiting

  function automatic int wt(input int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit m_keeps();
    return req[m_owner] && m_burst > 0 && m_burst < wt(m_owner);
  endfunction

  // Predicted grant index, -1 for no grant.
  function automatic int m_pick();
    logic [N-1:0] cand;
    if (m_waiting) return m_held;
    if (req == '0) return -1;
    if (m_keeps()) return m_owner;
    cand = req;
    if (|(req & prio)) cand = req & prio;
    for (int k = 1; k <= N; k++) begin
      if (cand[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = N - 1; m_burst = 0; m_waiting = 0; m_held = 0;
    end else begin
      int p;
      bit kept;
      p = m_pick();
      if (!m_waiting && p >= 0) begin
        kept = m_keeps();
        m_burst = kept ? ((m_burst + 1 > 7) ? 7 : m_burst + 1) : 1;
        m_owner = p;
      end
      if (p >= 0) m_held = p;
      m_waiting = !ready && (m_waiting || req != '0);
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      int e;
      e = m_pick();
      check("model_gnt", int'(gnt), (e < 0) ? 0 : (1 << e));
      check("model_idx", int'(gnt_idx), (e < 0) ? 0 : e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  // One cycle of stimulus; lit >= 0 pins the index, lit == -1 pins no grant,
  // lit == -2 leaves it to the model only.
  task automatic cyc(input logic [N-1:0] r, input logic rdy, input int lit);
    req = r;
    ready = rdy;
    @(negedge clk);
    if (lit >= 0) begin
      check("lit_idx", int'(gnt_idx), lit);
      check("lit_gnt", int'(gnt), 1 << lit);
    end else if (lit == -1) begin
      check("lit_idle", int'(gnt), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; ready = 1'b0; prio = '0;
    rst_n = 1'b0;
    #2;
    check("reset_gnt", int'(gnt), 0);
    check("reset_idx", int'(gnt_idx), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

    do_reset();

    // Plain round robin, all weights 1.
    set_w(1, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b1, i % 4);

    // Burst of 3 for requester 0.
    do_reset();
    set_w(3, 1, 1, 1);
    foreach (seq2[i]) cyc(4'b1111, 1'b1, seq2[i]);

    // Hold while not ready, granted bit dropping mid-hold.
    do_reset();
    set_w(1, 1, 1, 1);
    cyc(4'b0101, 1'b0, 0);
    cyc(4'b0101, 1'b0, 0);
    cyc(4'b0100, 1'b0, 0);
    cyc(4'b0100, 1'b1, 0);
    cyc(4'b0100, 1'b1, 2);

    // Owner drops mid-burst; new owner's burst starts at 1 (weight 2 -> two grants).
    do_reset();
    set_w(4, 2, 1, 1);
    cyc(4'b0011, 1'b1, 0);
    cyc(4'b0011, 1'b1, 0);
    cyc(4'b0010, 1'b1, 1);
    cyc(4'b0010, 1'b1, 1);
    cyc(4'b0011, 1'b1, 0);

    // Lowering the weight mid-burst ends it at the next arbitration.
    do_reset();
    set_w(4, 1, 1, 1);
    cyc(4'b0011, 1'b1, 0);
    cyc(4'b0011, 1'b1, 0);
    set_w(1, 1, 1, 1);
    cyc(4'b0011, 1'b1, 1);

    // Zero weights behave as one.
    do_reset();
    set_w(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0110, 1'b1, (i % 2 == 0) ? 1 : 2);

    // Single requester granted every cycle across burst boundaries.
    do_reset();
    set_w(1, 1, 3, 1);
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b1, 2);

    // Idle cycle.
    cyc(4'b0000, 1'b1, -1);

    // Asynchronous reset during a hold: grant re-arbitrates from reset state.
    do_reset();
    set_w(1, 1, 1, 1);
    cyc(4'b0100, 1'b0, 2);
    req = 4'b0011;
    #2;
    check("hold_idx", int'(gnt_idx), 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_idx", int'(gnt_idx), 0);
    check("async_rst_gnt", int'(gnt), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(4'b0011, 1'b1, 0);
    cyc(4'b0011, 1'b1, 1);

`ifdef HPDCACHE_WRRARB_PRIO_EN
    // High priority wins every arbitration.
    do_reset();
    set_w(1, 1, 1, 1);
    prio = 4'b1000;
    for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1, 3);

    // High priority never preempts a running burst.
    do_reset();
    set_w(2, 1, 1, 1);
    cyc(4'b1111, 1'b1, 0);
    prio = 4'b1000;
    cyc(4'b1111, 1'b1, 0);
    cyc(4'b1111, 1'b1, 3);
    cyc(4'b1111, 1'b1, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
